phase1_puzzle_dial_seq: RTL and testbench

Multi-stage successor to the phase-1 dial puzzle. The player must dial a sequence of SEQ_LEN LFSR-generated target positions in order, confirming each one with a button click. A strike counter allows MAX_FAILS-1 recoverable mistakes before a terminal fail. The block sits in the phase-1 puzzle set, is driven by the game FSM via enable, and feeds the 7-seg, LED bar and servo drivers.

---
 rtl/phase1_puzzle_dial_seq_pkg.sv | 21 ++
 rtl/phase1_puzzle_dial_seq_if.sv | 32 +++
 rtl/phase1_puzzle_dial_seq_lfsr.sv | 19 +
 rtl/phase1_puzzle_dial_seq.sv | 151 +++++++++++++++
 tb/tb_phase1_puzzle_dial_seq.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phase1_puzzle_dial_seq_pkg.sv
// Shared types and constants for the phase-1 dial puzzles.
package phase1_puzzle_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARMED,
        DONE,
        LOCKOUT
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci feedback taps at bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [3:0]  BLANK_NIB = 4'hF;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/phase1_puzzle_dial_seq_if.sv
// Game-FSM <-> dial-sequence puzzle signal bundle; master = game side, slave = puzzle.
interface phase1_puzzle_dial_seq_if #(
    parameter int POS_BITS = 3,
    parameter int ADC_W    = 12
);
    localparam int NPOS = 2 ** POS_BITS;

    logic                  enable;
    logic [ADC_W-1:0]      adc_dial_val;
    logic                  btn_click;
    logic [4*NPOS-1:0]     target_seg_data;
    logic [NPOS-1:0]       cursor_led;
    logic [7:0]            servo_angle;
    logic [2:0]            stage;
    logic [3:0]            strikes;
    logic [POS_BITS-1:0]   cur_target;
    logic                  clear;
    logic                  fail;

    modport master (
        output enable, adc_dial_val, btn_click,
        input  target_seg_data, cursor_led, servo_angle, stage, strikes,
               cur_target, clear, fail
    );

    modport slave (
        input  enable, adc_dial_val, btn_click,
        output target_seg_data, cursor_led, servo_angle, stage, strikes,
               cur_target, clear, fail
    );

endinterface

// File: rtl/phase1_puzzle_dial_seq_lfsr.sv
// 16-bit free-running Fibonacci LFSR shared by the phase-1 puzzles.
module puzzle_lfsr16
    import phase1_puzzle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) r_q <= LFSR_SEED;
        else     r_q <= lfsr_next(r_q);
    end

    assign q = r_q;

endmodule

// File: rtl/phase1_puzzle_dial_seq.sv
// Dial-sequence puzzle: dial SEQ_LEN LFSR targets in order, MAX_FAILS strikes to lock out.
// Optional macro DIAL_SETTLE_EN: clicks accepted only after SETTLE_CYCLES of stable dial.
module phase1_puzzle_dial_seq
    import phase1_puzzle_pkg::*;
#(
    parameter int POS_BITS      = 3,
    parameter int ADC_W         = 12,
    parameter int SEQ_LEN       = 3,
    parameter int MAX_FAILS     = 3,
    parameter int SERVO_STEP    = 25,
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    phase1_puzzle_dial_seq_if.slave    bus
);

    localparam int NPOS = 2 ** POS_BITS;
    typedef logic [POS_BITS-1:0] pos_t;

    state_t      r_state, w_state_nxt;
    pos_t        r_targets [8];
    pos_t        w_targets_nxt [8];
    logic [2:0]  r_idx, w_idx_nxt;
    logic [2:0]  r_stage, w_stage_nxt;
    logic [3:0]  r_strikes, w_strikes_nxt;
    logic        r_clear, w_clear_nxt;
    logic        r_fail, w_fail_nxt;
    pos_t        r_pos;
    pos_t        w_pos, w_t_raw, w_cur_target;
    logic [15:0] w_lfsr;
    logic        w_settled, w_click;
    logic [4*NPOS-1:0] w_seg;

    puzzle_lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    assign w_pos        = bus.adc_dial_val[ADC_W-1 -: POS_BITS];
    assign w_t_raw      = w_lfsr[POS_BITS-1:0];
    assign w_cur_target = r_targets[r_stage];

`ifdef DIAL_SETTLE_EN
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    logic [SET_W-1:0] r_settle_cnt;

    always_ff @(posedge clk) begin
        if (rst || (w_pos != r_pos))
            r_settle_cnt <= '0;
        else if (r_settle_cnt != SET_W'(SETTLE_CYCLES))
            r_settle_cnt <= r_settle_cnt + SET_W'(1);
    end

    assign w_settled = (r_settle_cnt == SET_W'(SETTLE_CYCLES));
`else
    assign w_settled = (SETTLE_CYCLES >= 0);
`endif

    assign w_click = bus.btn_click & w_settled;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_targets <= '{default: '0};
            r_idx     <= '0;
            r_stage   <= '0;
            r_strikes <= '0;
            r_clear   <= 1'b0;
            r_fail    <= 1'b0;
            r_pos     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_targets <= w_targets_nxt;
            r_idx     <= w_idx_nxt;
            r_stage   <= w_stage_nxt;
            r_strikes <= w_strikes_nxt;
            r_clear   <= w_clear_nxt;
            r_fail    <= w_fail_nxt;
            r_pos     <= w_pos;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_targets_nxt = r_targets;
        w_idx_nxt     = r_idx;
        w_stage_nxt   = r_stage;
        w_strikes_nxt = r_strikes;
        w_clear_nxt   = 1'b0;
        w_fail_nxt    = 1'b0;
        if (!bus.enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt   = LOAD;
                    w_idx_nxt     = '0;
                    w_stage_nxt   = '0;
                    w_strikes_nxt = '0;
                end
                LOAD: begin
                    // bump a repeat so consecutive targets always differ
                    if ((r_idx != 3'd0) && (w_t_raw == r_targets[r_idx - 3'd1]))
                        w_targets_nxt[r_idx] = w_t_raw + pos_t'(1);
                    else
                        w_targets_nxt[r_idx] = w_t_raw;
                    if (r_idx == 3'(SEQ_LEN - 1)) w_state_nxt = ARMED;
                    else                          w_idx_nxt   = r_idx + 3'd1;
                end
                ARMED: begin
                    if (w_click) begin
                        if (r_pos == w_cur_target) begin
                            if (r_stage == 3'(SEQ_LEN - 1)) begin
                                w_clear_nxt = 1'b1;
                                w_state_nxt = DONE;
                            end else begin
                                w_stage_nxt = r_stage + 3'd1;
                            end
                        end else begin
                            w_strikes_nxt = r_strikes + 4'd1;
                            if (w_strikes_nxt == 4'(MAX_FAILS)) begin
                                w_fail_nxt  = 1'b1;
                                w_state_nxt = LOCKOUT;
                            end else begin
                                w_stage_nxt = '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NPOS; i++) w_seg[4*i +: 4] = BLANK_NIB;
        if (r_state == ARMED) w_seg[4*w_cur_target +: 4] = 4'h0;
    end

    assign bus.target_seg_data = w_seg;
    assign bus.cursor_led      = NPOS'(1) << w_pos;
    assign bus.servo_angle     = 8'(int'(w_pos) * SERVO_STEP);
    assign bus.stage           = r_stage;
    assign bus.strikes         = r_strikes;
    assign bus.cur_target      = w_cur_target;
    assign bus.clear           = r_clear;
    assign bus.fail            = r_fail;

endmodule

// File: tb/tb_phase1_puzzle_dial_seq.sv
// Self-checking bench for phase1_puzzle_dial_seq: vector table, directed sequences, random play vs model.
module tb_phase1_puzzle_dial_seq;

    localparam int SEQ  = 3;
    localparam int MAXF = 3;
`ifdef DIAL_SETTLE_EN
    localparam int SETTLE = 8;
    localparam int PRE    = 10;
`else
    localparam int SETTLE = 1000;
    localparam int PRE    = 1;
`endif
    localparam logic [31:0] ALL_F = 32'hFFFF_FFFF;

    typedef struct {
        logic [11:0] adc;
        logic [7:0]  led;
        logic [7:0]  servo;
    } comb_vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_lfsr;
    logic [2:0]  m_tgt [SEQ];
    comb_vec_t   vecs [8];

    phase1_puzzle_dial_seq_if #(.POS_BITS(3), .ADC_W(12)) bus ();

    phase1_puzzle_dial_seq #(
        .POS_BITS      (3),
        .ADC_W         (12),
        .SEQ_LEN       (SEQ),
        .MAX_FAILS     (MAXF),
        .SERVO_STEP    (25),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // reference copy of the free-running LFSR, used to predict loaded targets
    always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : lstep(m_lfsr);

    function automatic logic [31:0] seg_for(input logic [2:0] t);
        logic [31:0] s = ALL_F;
        s[4*t +: 4] = 4'h0;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start();
        logic [15:0] v;
        logic [2:0]  t;
        bus.enable = 1'b1;
        cyc();
        v = m_lfsr;
        for (int k = 0; k < SEQ; k++) begin
            t = v[2:0];
            if (k > 0 && t == m_tgt[k-1]) t = t + 3'd1;
            m_tgt[k] = t;
            v = lstep(v);
        end
        for (int k = 0; k < SEQ; k++) begin
            chk("load_blank", bus.target_seg_data, ALL_F);
            cyc();
        end
        chk("armed_stage", 32'(bus.stage), 32'd0);
        chk("armed_strikes", 32'(bus.strikes), 32'd0);
        chk("armed_target", 32'(bus.cur_target), 32'(m_tgt[0]));
        chk("armed_seg", bus.target_seg_data, seg_for(m_tgt[0]));
    endtask

    task automatic click(input logic [2:0] p);
        bus.adc_dial_val = {p, 9'd0};
        repeat (PRE) cyc();
        bus.btn_click = 1'b1;
        cyc();
        bus.btn_click = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         m_stage, m_strikes;
        bit         good, done;
        logic       exp_clear, exp_fail;
        logic [2:0] p;

        vecs = '{
            '{12'h000, 8'h01, 8'd0},   '{12'h200, 8'h02, 8'd25},
            '{12'h5FF, 8'h04, 8'd50},  '{12'h600, 8'h08, 8'd75},
            '{12'h9AB, 8'h10, 8'd100}, '{12'hA00, 8'h20, 8'd125},
            '{12'hC01, 8'h40, 8'd150}, '{12'hFFF, 8'h80, 8'd175}
        };
        bus.enable       = 1'b0;
        bus.btn_click    = 1'b0;
        bus.adc_dial_val = '0;

        // reset state
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst_stage", 32'(bus.stage), 32'd0);
        chk("rst_strikes", 32'(bus.strikes), 32'd0);
        chk("rst_clear", 32'(bus.clear), 32'd0);
        chk("rst_fail", 32'(bus.fail), 32'd0);
        chk("rst_target", 32'(bus.cur_target), 32'd0);
        chk("rst_seg", bus.target_seg_data, ALL_F);

        // combinational dial decode table
        foreach (vecs[i]) begin
            bus.adc_dial_val = vecs[i].adc;
            #1;
            chk("tbl_led", 32'(bus.cursor_led), 32'(vecs[i].led));
            chk("tbl_servo", 32'(bus.servo_angle), 32'(vecs[i].servo));
        end
        @(negedge clk);

        // full success sequence
        start();
        for (int s = 0; s < SEQ; s++)
            if (s > 0) chk("tgt_differ", 32'(m_tgt[s] != m_tgt[s-1]), 32'd1);
        click(m_tgt[0]);
        chk("ok_stage1", 32'(bus.stage), 32'd1);
        chk("ok_tgt1", 32'(bus.cur_target), 32'(m_tgt[1]));
        chk("ok_seg1", bus.target_seg_data, seg_for(m_tgt[1]));
        click(m_tgt[1]);
        chk("ok_stage2", 32'(bus.stage), 32'd2);
        chk("ok_noclear", 32'(bus.clear), 32'd0);
        click(m_tgt[2]);
        chk("ok_clear", 32'(bus.clear), 32'd1);
        chk("ok_nofail", 32'(bus.fail), 32'd0);
        chk("done_seg", bus.target_seg_data, ALL_F);
        cyc();
        chk("ok_clear_1cyc", 32'(bus.clear), 32'd0);
        click(m_tgt[2]);
        chk("done_ignore", 32'(bus.clear), 32'd0);
        bus.adc_dial_val = 12'hE00;
        #1;
        chk("servo_pos7", 32'(bus.servo_angle), 32'd175);
        chk("led_pos7", 32'(bus.cursor_led), 32'h80);
        @(negedge clk);
        bus.enable = 1'b0;
        cyc();

        // strikes and lockout
        start();
        click(m_tgt[0]);
        click(m_tgt[1] + 3'd1);
        chk("bad1_strikes", 32'(bus.strikes), 32'd1);
        chk("bad1_stage", 32'(bus.stage), 32'd0);
        chk("bad1_nofail", 32'(bus.fail), 32'd0);
        click(m_tgt[0] + 3'd1);
        chk("bad2_strikes", 32'(bus.strikes), 32'd2);
        chk("bad2_nofail", 32'(bus.fail), 32'd0);
        click(m_tgt[0] + 3'd1);
        chk("bad3_fail", 32'(bus.fail), 32'd1);
        chk("bad3_noclear", 32'(bus.clear), 32'd0);
        chk("bad3_strikes", 32'(bus.strikes), 32'd3);
        chk("lock_seg", bus.target_seg_data, ALL_F);
        cyc();
        chk("fail_1cyc", 32'(bus.fail), 32'd0);
        click(m_tgt[0]);
        chk("lock_noclear", 32'(bus.clear), 32'd0);
        chk("lock_nofail", 32'(bus.fail), 32'd0);
        chk("lock_strikes", 32'(bus.strikes), 32'd3);
        bus.enable = 1'b0;
        cyc();

        // abort mid-puzzle, then re-enable with fresh targets
        start();
        click(m_tgt[0]);
        click(m_tgt[1] + 3'd1);
        click(m_tgt[0]);
        chk("abort_pre_stage", 32'(bus.stage), 32'd1);
        bus.enable = 1'b0;
        cyc();
        chk("abort_seg", bus.target_seg_data, ALL_F);
        start();
        chk("reen_strikes", 32'(bus.strikes), 32'd0);
        // click in the same cycle enable falls is dropped
        click(m_tgt[0]);
        click(m_tgt[1]);
        bus.adc_dial_val = {m_tgt[2], 9'd0};
        repeat (PRE) cyc();
        bus.enable    = 1'b0;
        bus.btn_click = 1'b1;
        cyc();
        bus.btn_click = 1'b0;
        chk("fall_noclear", 32'(bus.clear), 32'd0);
        chk("fall_seg", bus.target_seg_data, ALL_F);

        // reset coinciding with a winning click
        start();
        click(m_tgt[0]);
        click(m_tgt[1]);
        bus.adc_dial_val = {m_tgt[2], 9'd0};
        repeat (PRE) cyc();
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.btn_click = 1'b1;
        cyc();
        rst           = 1'b0;
        bus.btn_click = 1'b0;
        chk("rstclk_clear", 32'(bus.clear), 32'd0);
        chk("rstclk_fail", 32'(bus.fail), 32'd0);
        chk("rstclk_stage", 32'(bus.stage), 32'd0);
        chk("rstclk_seg", bus.target_seg_data, ALL_F);
        cyc();
        chk("rstclk_clear2", 32'(bus.clear), 32'd0);

`ifdef DIAL_SETTLE_EN
        start();
        bus.adc_dial_val = {m_tgt[0] + 3'd1, 9'd0};
        repeat (3) cyc();
        bus.adc_dial_val = {m_tgt[0], 9'd0};
        repeat (3) cyc();
        bus.btn_click = 1'b1;
        cyc();
        bus.btn_click = 1'b0;
        chk("settle_early_stage", 32'(bus.stage), 32'd0);
        chk("settle_early_strikes", 32'(bus.strikes), 32'd0);
        repeat (8) cyc();
        bus.btn_click = 1'b1;
        cyc();
        bus.btn_click = 1'b0;
        chk("settle_ok_stage", 32'(bus.stage), 32'd1);
        bus.enable = 1'b0;
        cyc();
`endif

        // random play against the puzzle rules
        for (int r = 0; r < 12; r++) begin
            start();
            m_stage   = 0;
            m_strikes = 0;
            done      = 0;
            while (!done) begin
                good = ($urandom_range(0, 2) != 0);
                p = good ? m_tgt[m_stage] : 3'(m_tgt[m_stage] + $urandom_range(1, 7));
                click(p);
                exp_clear = 1'b0;
                exp_fail  = 1'b0;
                if (good) begin
                    if (m_stage == SEQ - 1) begin
                        exp_clear = 1'b1;
                        done      = 1;
                    end else begin
                        m_stage++;
                    end
                end else begin
                    m_strikes++;
                    if (m_strikes == MAXF) begin
                        exp_fail = 1'b1;
                        done     = 1;
                    end else begin
                        m_stage = 0;
                    end
                end
                chk("rnd_clear", 32'(bus.clear), 32'(exp_clear));
                chk("rnd_fail", 32'(bus.fail), 32'(exp_fail));
                chk("rnd_strikes", 32'(bus.strikes), 32'(m_strikes));
                if (!done) begin
                    chk("rnd_stage", 32'(bus.stage), 32'(m_stage));
                    chk("rnd_target", 32'(bus.cur_target), 32'(m_tgt[m_stage]));
                end
            end
            chk("rnd_end_seg", bus.target_seg_data, ALL_F);
            cyc();
            chk("rnd_pulse_gone", 32'(bus.clear | bus.fail), 32'd0);
            p = 3'($urandom_range(0, 7));
            bus.adc_dial_val = {p, 9'($urandom_range(0, 511))};
            #1;
            chk("rnd_led", 32'(bus.cursor_led), 32'(8'(1 << p)));
            chk("rnd_servo", 32'(bus.servo_angle), (32'(p) * 25) & 32'hFF);
            @(negedge clk);
            bus.enable = 1'b0;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
